// File: rtl/lgdst_ts_pkg.sv
// Shared constants and capture FSM encoding for the serial TS packet FIFO.
package lgdst_ts_pkg;

  localparam int         TS_PKT_LEN   = 188;
  localparam int         TS_PKT_BITS  = TS_PKT_LEN * 8;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DROP    = 2'd2
  } ts_cap_state_t;

endpackage

// File: rtl/lgdst_ts_dpram.sv
// Simple dual-port byte RAM: one write port, one registered read port, single clock.
module lgdst_ts_dpram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // Write port; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port; output register clears on reset so rd_data starts at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lgdst_ts_pkt_fifo.sv
// Serial TS capture into a packet-committed byte FIFO.
// Optional build macro TS_SYNCBYTE_CHK_EN: abort a packet whose first byte is not 0x47.
//
// state      | meaning
// IDLE       | waiting for sync&valid on a sample strobe
// CAPTURE    | shifting bits of an accepted packet into the FIFO (speculative)
// DROP       | discarding the rest of a packet that has no room or a bad sync byte
module lgdst_ts_pkt_fifo
  import lgdst_ts_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ts_clk,
  input  logic        ts_d0,
  input  logic        ts_valid,
  input  logic        ts_sync,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        fifo_empty,
  output logic [AW:0] fifo_level,
  output logic [7:0]  pkt_drop_cnt,
  output logic        pkt_err
);

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] MAX_USED  = (AW+1)'(DEPTH - TS_PKT_LEN);
  localparam logic [10:0] DROP_FULL = 11'(TS_PKT_BITS - 1);
  localparam logic [7:0]  LAST_BYTE = 8'(TS_PKT_LEN - 1);

  logic [2:0] clk_sync_q;
  logic [1:0] d0_sync_q, vld_sync_q, sof_sync_q;

  ts_cap_state_t state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [10:0]   drop_rem_q, drop_rem_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q;
  logic          wr_req_q, wr_req_d, commit_pend_q, commit_pend_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          pkt_err_q, pkt_err_d, rd_valid_q;

  logic       strobe, d0_s, vld_s, sof_s, start, room_ok, rd_accept;
  logic [7:0] nxt_byte;

  // Two-flop synchronisers; a third ts_clk stage gives the rising-edge strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '0;
      d0_sync_q  <= '0;
      vld_sync_q <= '0;
      sof_sync_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ts_clk};
      d0_sync_q  <= {d0_sync_q[0], ts_d0};
      vld_sync_q <= {vld_sync_q[0], ts_valid};
      sof_sync_q <= {sof_sync_q[0], ts_sync};
    end
  end

  assign strobe   = clk_sync_q[1] & ~clk_sync_q[2];
  assign d0_s     = d0_sync_q[1];
  assign vld_s    = vld_sync_q[1];
  assign sof_s    = sof_sync_q[1];
  assign nxt_byte = {d0_s, sh_q[7:1]};
  // wr_ptr equals wr_commit whenever a packet can start (idle or just rolled back).
  assign room_ok  = (wr_commit_q - rd_ptr_q) <= MAX_USED;

  // Capture FSM, deserialiser and speculative write pointer.
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    drop_rem_d    = drop_rem_q;
    wr_ptr_d      = wr_ptr_q;
    wr_commit_d   = wr_commit_q;
    wr_req_d      = 1'b0;
    wr_data_d     = wr_data_q;
    wr_addr_d     = wr_addr_q;
    commit_pend_d = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    pkt_err_d     = 1'b0;
    start         = 1'b0;

    // Last byte is written to RAM on this same edge, so publishing it now is safe.
    if (commit_pend_q) wr_commit_d = wr_ptr_q;

    if (strobe) begin
      case (state_q)
        ST_IDLE: start = vld_s & sof_s;
        ST_CAPTURE: begin
          if (!vld_s) begin
            wr_ptr_d  = wr_commit_q;
            pkt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (sof_s && (bit_cnt_q != 3'd0 || byte_cnt_q != 8'd0)) begin
            wr_ptr_d  = wr_commit_q;
            pkt_err_d = 1'b1;
            start     = 1'b1;
          end else begin
            sh_d      = nxt_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_req_d   = 1'b1;
              wr_data_d  = nxt_byte;
              wr_addr_d  = wr_ptr_q[AW-1:0];
              wr_ptr_d   = wr_ptr_q + PTR_ONE;
              byte_cnt_d = byte_cnt_q + 8'd1;
              if (byte_cnt_q == LAST_BYTE) begin
                commit_pend_d = 1'b1;
                state_d       = ST_IDLE;
              end
`ifdef TS_SYNCBYTE_CHK_EN
              if (byte_cnt_q == 8'd0 && nxt_byte != TS_SYNC_BYTE) begin
                wr_req_d   = 1'b0;
                wr_ptr_d   = wr_commit_q;
                pkt_err_d  = 1'b1;
                state_d    = ST_DROP;
                drop_rem_d = 11'(TS_PKT_BITS - 8);
              end
`endif
            end
          end
        end
        ST_DROP: begin
          if (!vld_s) begin
            state_d = ST_IDLE;
          end else begin
            drop_rem_d = drop_rem_q - 11'd1;
            if (drop_rem_q == 11'd1) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The sync bit itself is the first data bit of the packet.
    if (start) begin
      if (room_ok) begin
        state_d    = ST_CAPTURE;
        sh_d       = nxt_byte;
        bit_cnt_d  = 3'd1;
        byte_cnt_d = 8'd0;
      end else begin
        state_d    = ST_DROP;
        drop_rem_d = DROP_FULL;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // Capture-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sh_q          <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      drop_rem_q    <= '0;
      wr_ptr_q      <= '0;
      wr_commit_q   <= '0;
      wr_req_q      <= 1'b0;
      wr_data_q     <= '0;
      wr_addr_q     <= '0;
      commit_pend_q <= 1'b0;
      drop_cnt_q    <= '0;
      pkt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      drop_rem_q    <= drop_rem_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_commit_q   <= wr_commit_d;
      wr_req_q      <= wr_req_d;
      wr_data_q     <= wr_data_d;
      wr_addr_q     <= wr_addr_d;
      commit_pend_q <= commit_pend_d;
      drop_cnt_q    <= drop_cnt_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  assign fifo_level = wr_commit_q - rd_ptr_q;
  assign fifo_empty = (fifo_level == '0);
  assign rd_accept  = rd_en & ~fifo_empty;

  // Pop side: read pointer and the valid strobe that tracks the RAM read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rd_accept) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      rd_valid_q <= rd_accept;
    end
  end

  lgdst_ts_dpram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_req_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_q),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign pkt_err      = pkt_err_q;

endmodule

// File: tb/tb_lgdst_ts_pkt_fifo.sv
// Directed bench for lgdst_ts_pkt_fifo with a byte scoreboard.
module tb_lgdst_ts_pkt_fifo;

  localparam int PKT_BITS = 1504;

  logic clk = 1'b0, rst = 1'b1, rst_s = 1'b1;
  logic ts_clk = 1'b0, ts_d0 = 1'b0, ts_valid = 1'b0, ts_sync = 1'b0;
  logic rd_en = 1'b0, rd_en_s = 1'b0;

  logic [7:0]  rd_data, rd_data_s, drop, drop_s;
  logic        rd_valid, rd_valid_s, fifo_empty, fifo_empty_s, pkt_err, pkt_err_s;
  logic [10:0] fifo_level;
  logic [8:0]  fifo_level_s;

  int checks = 0, errors = 0;
  int model_level = 0, err_seen = 0, lat = 0, e0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt [188];

  lgdst_ts_pkt_fifo #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .ts_clk(ts_clk), .ts_d0(ts_d0), .ts_valid(ts_valid),
    .ts_sync(ts_sync), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .pkt_drop_cnt(drop),
    .pkt_err(pkt_err)
  );

  lgdst_ts_pkt_fifo #(.DEPTH(256), .AW(8)) dut_s (
    .clk(clk), .rst(rst_s), .ts_clk(ts_clk), .ts_d0(ts_d0), .ts_valid(ts_valid),
    .ts_sync(ts_sync), .rd_en(rd_en_s), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .fifo_empty(fifo_empty_s), .fifo_level(fifo_level_s), .pkt_drop_cnt(drop_s),
    .pkt_err(pkt_err_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pkt_err === 1'b1) err_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_pkt(input logic [7:0] first);
    pkt[0] = first;
    for (int i = 1; i < 188; i++) pkt[i] = 8'(i - 1);
  endtask

  task automatic push_pkt();
    for (int i = 0; i < 188; i++) exp_q.push_back(pkt[i]);
    model_level += 188;
  endtask

  task automatic send_bit(input logic d, input logic v, input logic s, input int half);
    ts_d0 = d; ts_valid = v; ts_sync = s; ts_clk = 1'b0;
    repeat (half) @(posedge clk);
    #1 ts_clk = 1'b1;
    repeat (half) @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_valid_empty"}, rd_valid, 1'b0);
    end else begin
      e = exp_q.pop_front();
      model_level--;
      chk({tag, "_valid"}, rd_valid, 1'b1);
      chk({tag, "_data"}, rd_data, e);
    end
  endtask

  task automatic pop_n(input string tag, input int n);
    for (int i = 0; i < n; i++) pop_chk(tag);
    chk({tag, "_level"}, fifo_level, model_level);
  endtask

  // mode 1 measures commit latency, mode 2 pops in the commit clock.
  task automatic last_bit(input logic d, input int half, input int mode);
    ts_d0 = d; ts_valid = 1'b1; ts_sync = 1'b0; ts_clk = 1'b0;
    repeat (half) @(posedge clk);
    #1 ts_clk = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (mode == 2 && c == lat) rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      if (mode == 1 && lat == 0 && fifo_level == 11'(model_level)) lat = c;
      if (mode == 2 && c == lat) begin
        model_level--;
        chk("t6_commit_pop_level", fifo_level, model_level);
        chk("t6_commit_pop_valid", rd_valid, 1'b1);
        chk("t6_commit_pop_data", rd_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic send_pkt(input int vbits, input int rst_bit, input int mode, input int half);
    for (int bi = 0; bi < vbits; bi++) begin
      logic b;
      b = pkt[bi / 8][bi % 8];
      if (bi == rst_bit) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_level = 0;
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_empty", fifo_empty, 1'b1);
        chk("t5_rst_drop", drop, 0);
      end
      if (bi == PKT_BITS - 1 && mode != 0) last_bit(b, half, mode);
      else send_bit(b, 1'b1, bi == 0, half);
    end
    repeat (2) send_bit(1'b0, 1'b0, 1'b0, half);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop, 0);
    chk("rst_pkt_err", pkt_err, 1'b0);

    // 1: good packet at ts_clk = clk/8
    build_pkt(8'h47);
    push_pkt();
    send_pkt(PKT_BITS, -1, 1, 4);
    chk("t1_level", fifo_level, 188);
    chk("t1_latency_le5", (lat >= 1 && lat <= 5), 1'b1);
    if (lat == 0) lat = 4;
    pop_n("t1_pop", 188);
    chk("t1_empty", fifo_empty, 1'b1);

    // 2: valid drops at byte 100, then a good packet
    e0 = err_seen;
    send_pkt(800, -1, 0, 2);
    chk("t2_err_pulse", err_seen, e0 + 1);
    chk("t2_level", fifo_level, 0);
    push_pkt();
    send_pkt(PKT_BITS, -1, 0, 2);
    chk("t2_good_level", fifo_level, 188);
    pop_n("t2_pop", 188);

    // 3: two packets into the 256-byte instance, no reads
    rst_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e0 = err_seen;
    push_pkt();
    send_pkt(PKT_BITS, -1, 0, 2);
    push_pkt();
    send_pkt(PKT_BITS, -1, 0, 2);
    chk("t3_small_level", fifo_level_s, 188);
    chk("t3_small_drop", drop_s, 1);
    chk("t3_main_level", fifo_level, 376);
    chk("t3_main_drop", drop, 0);
    chk("t3_no_err", err_seen, e0);
    pop_n("t3_pop", 376);

    // 4: wrong first byte
    build_pkt(8'h00);
    e0 = err_seen;
`ifdef TS_SYNCBYTE_CHK_EN
    send_pkt(PKT_BITS, -1, 0, 2);
    chk("t4_err_pulse", err_seen, e0 + 1);
    chk("t4_level", fifo_level, 0);
`else
    push_pkt();
    send_pkt(PKT_BITS, -1, 0, 2);
    chk("t4_level", fifo_level, 188);
    pop_chk("t4_pop");
    chk("t4_first_byte", rd_data, 8'h00);
`endif

    // 5: reset at byte 50, then a clean packet
    build_pkt(8'h47);
    send_pkt(PKT_BITS, 400, 0, 2);
    chk("t5_after_level", fifo_level, 0);
    push_pkt();
    send_pkt(PKT_BITS, -1, 0, 2);
    chk("t5_good_level", fifo_level, 188);

    // 6: pop in the commit clock with 10 bytes held
    pop_n("t6_drain", 178);
    chk("t6_level10", fifo_level, 10);
    push_pkt();
    send_pkt(PKT_BITS, -1, 2, 2);
    chk("t6_level197", fifo_level, 197);
    pop_n("t6_pop", 197);
    chk("t6_empty", fifo_empty, 1'b1);

    // read while empty
    pop_chk("empty_rd");
    chk("empty_rd_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
